// File: rtl/gf128_pkg.sv
// Shared types and the single-bit V update for the GCM-order GF(2^128) multiplier.
package gf128_pkg;

    typedef logic [127:0] gf128_t;

    // x^128 = x^7 + x^2 + x + 1, bit-reflected into GCM order
    localparam gf128_t GF128_R = {8'hE1, 120'h0};

    typedef enum logic [1:0] {IDLE, CALC, DONE} gf_mul_state_e;

    // One V step: multiply V by x, reducing when the x^127 coefficient (bit 0) falls off
    function automatic gf128_t gf128_shr_red(input gf128_t v);
        return v[0] ? ((v >> 1) ^ GF128_R) : (v >> 1);
    endfunction

endpackage

// File: rtl/gf128_digit_step.sv
// Combinational slice of the serial multiplier: DIGIT_W bits of X folded into Z, V advanced DIGIT_W times.
module gf128_digit_step
    import gf128_pkg::*;
#(
    parameter int DIGIT_W = 8
) (
    input  gf128_t               z_i,
    input  gf128_t               v_i,
    input  logic [DIGIT_W-1:0]   x_i,
    output gf128_t               z_o,
    output gf128_t               v_o
);

    gf128_t z_acc;
    gf128_t v_acc;

    // x_i[DIGIT_W-1] is the lowest-degree coefficient of this digit, so it goes first
    always_comb begin
        z_acc = z_i;
        v_acc = v_i;
        for (int i = DIGIT_W - 1; i >= 0; i--) begin
            if (x_i[i]) z_acc = z_acc ^ v_acc;
            v_acc = gf128_shr_red(v_acc);
        end
    end

    assign z_o = z_acc;
    assign v_o = v_acc;

endmodule

// File: rtl/gf128_mul_serial.sv
// Digit-serial GF(2^128) multiplier (GHASH engine), valid/ready on both sides.
// Define GF128_MUL_ACC_EN to add the GHASH chaining accumulator and the acc_clr_i port.
module gf128_mul_serial
    import gf128_pkg::*;
#(
    parameter int DIGIT_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] a_i,
    input  logic [127:0] b_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] result_o,
`ifdef GF128_MUL_ACC_EN
    input  logic         acc_clr_i,
`endif
    output logic         busy_o
);

    localparam int NDIG  = (DIGIT_W > 0) ? 128 / DIGIT_W : 1;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    if (DIGIT_W < 1 || DIGIT_W > 128 || (128 % DIGIT_W) != 0) begin : g_bad_digit
        $error("gf128_mul_serial: DIGIT_W=%0d must divide 128", DIGIT_W);
    end

    gf_mul_state_e      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    gf128_t             z_q, v_q, x_q, res_q;
    gf128_t             z_nx, v_nx, x_sh, y_eff;
    logic               oval_q;
    logic               accept, last, out_hs;

    assign accept = in_valid_i && in_ready_o;
    assign last   = (state_q == CALC) && (cnt_q == CNT_W'(NDIG - 1));
    assign out_hs = oval_q && out_ready_i;

    gf128_digit_step #(.DIGIT_W(DIGIT_W)) u_step (
        .z_i (z_q),
        .v_i (v_q),
        .x_i (x_q[127 -: DIGIT_W]),
        .z_o (z_nx),
        .v_o (v_nx)
    );

    if (DIGIT_W >= 128) begin : g_xsh_all
        assign x_sh = '0;
    end else begin : g_xsh
        assign x_sh = {x_q[127-DIGIT_W:0], {DIGIT_W{1'b0}}};
    end

`ifdef GF128_MUL_ACC_EN
    gf128_t y_q;

    // A result consumed on the same edge as a new accept must already feed the new X
    assign y_eff = acc_clr_i ? '0 : (out_hs ? res_q : y_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) y_q <= '0;
        else        y_q <= y_eff;
    end
`else
    assign y_eff = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    if (last) state_d = DONE;
            DONE:    if (out_ready_i) state_d = in_valid_i ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = (state_q == IDLE) || (state_q == DONE && out_ready_i);
        busy_o      = (state_q != IDLE);
        out_valid_o = oval_q;
        result_o    = res_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            z_q    <= '0;
            v_q    <= '0;
            x_q    <= '0;
            res_q  <= '0;
            oval_q <= 1'b0;
        end else begin
            if (accept) begin
                x_q   <= a_i ^ y_eff;
                v_q   <= b_i;
                z_q   <= '0;
                cnt_q <= '0;
            end else if (state_q == CALC) begin
                z_q   <= z_nx;
                v_q   <= v_nx;
                x_q   <= x_sh;
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (last) begin
                res_q  <= z_nx;
                oval_q <= 1'b1;
            end else if (out_hs) begin
                oval_q <= 1'b0;
            end
        end
    end

endmodule
